// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the branch/PC sequencer.
// Sequencer states, and the increments used for the sequential PC and the link address.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DSLOT = 2'd2
  } seq_state_t;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned LINK_INC = 8;

endpackage

// File: rtl/pc_incrementer.sv
// Adds a fixed constant to a PC value. The sum wraps modulo 2^W.
module pc_incrementer #(
  parameter int unsigned W   = 32,
  parameter int unsigned INC = 4
) (
  input  logic [W-1:0] operand_i,
  output logic [W-1:0] result_o
);

  assign result_o = operand_i + W'(INC);

endmodule

// File: rtl/branch_pc_sequencer.sv
// Sequences pc/npc for fetch, with a single MIPS branch delay slot after each accepted redirect.
// Also produces the link address, and one-cycle pulses for a dropped redirect or a misaligned target.
module branch_pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_enable,
  input  logic            take_branch,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic            fetch_valid,
  output logic            in_delay_slot,
  output logic [PC_W-1:0] link_addr,
  output logic            ds_violation,
  output logic            misalign
);

  localparam logic [PC_W-1:0] RESET_NPC = RESET_PC + PC_W'(PC_INC);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            ids_q, ids_d;
  logic            dsv_q, dsv_d;
  logic            mis_q, mis_d;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] npc_seq;

  pc_incrementer #(
    .W   (PC_W),
    .INC (PC_INC)
  ) u_npc_inc (
    .operand_i (npc_q),
    .result_o  (npc_seq)
  );

  pc_incrementer #(
    .W   (PC_W),
    .INC (LINK_INC)
  ) u_link_inc (
    .operand_i (pc_q),
    .result_o  (link_addr)
  );

  // A jump outranks a conditional branch that is taken in the same cycle.
  assign redirect = jump | take_branch;
  assign target   = jump ? jump_target : branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ids_d   = ids_q;
    dsv_d   = 1'b0;
    mis_d   = 1'b0;
    if (load_enable) begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          pc_d = npc_q;
          if (redirect) begin
            npc_d   = {target[PC_W-1:2], 2'b00};
            mis_d   = |target[1:0];
            ids_d   = 1'b1;
            state_d = DSLOT;
          end else begin
            npc_d = npc_seq;
          end
        end
        DSLOT: begin
          // The delay-slot instruction cannot redirect; the request is dropped and flagged.
          pc_d    = npc_q;
          npc_d   = npc_seq;
          ids_d   = 1'b0;
          dsv_d   = redirect;
          state_d = RUN;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      ids_q   <= 1'b0;
      dsv_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ids_q   <= ids_d;
      dsv_q   <= dsv_d;
      mis_q   <= mis_d;
    end
  end

  assign pc            = pc_q;
  assign npc           = npc_q;
  assign fetch_valid   = (state_q != BOOT);
  assign in_delay_slot = ids_q;
  assign ds_violation  = dsv_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed vectors, stall/reset/wrap sequences,
// then random traffic against a fetch-stream reference model.
module tb_branch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, load_enable, take_branch, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, npc, link_addr;
  logic        fetch_valid, in_delay_slot, ds_violation, misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_pc_sequencer #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_enable   (load_enable),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .npc           (npc),
    .fetch_valid   (fetch_valid),
    .in_delay_slot (in_delay_slot),
    .link_addr     (link_addr),
    .ds_violation  (ds_violation),
    .misalign      (misalign)
  );

  typedef struct {
    logic        rst_n;
    logic        le;
    logic        tb;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fv;
    logic        ids;
    logic        dsv;
    logic        mis;
  } vec_t;

  function automatic vec_t mkv(input logic rst_n, input logic le, input logic tb,
                               input logic [31:0] bt, input logic j, input logic [31:0] jt,
                               input logic [31:0] epc, input logic [31:0] enpc, input logic fv,
                               input logic ids, input logic dsv, input logic mis);
    vec_t v;
    v.rst_n = rst_n; v.le = le; v.tb = tb; v.bt = bt; v.j = j; v.jt = jt;
    v.pc = epc; v.npc = enpc; v.fv = fv; v.ids = ids; v.dsv = dsv; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare everything against the expectation.
  task automatic apply(input string tag, input vec_t v);
    reset_n       = v.rst_n;
    load_enable   = v.le;
    take_branch   = v.tb;
    branch_target = v.bt;
    jump          = v.j;
    jump_target   = v.jt;
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc, v.pc);
    chk({tag, ".npc"}, npc, v.npc);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(v.fv));
    chk({tag, ".in_delay_slot"}, 32'(in_delay_slot), 32'(v.ids));
    chk({tag, ".ds_violation"}, 32'(ds_violation), 32'(v.dsv));
    chk({tag, ".misalign"}, 32'(misalign), 32'(v.mis));
    if (v.fv) chk({tag, ".link_addr"}, link_addr, v.pc + 32'd8);
  endtask

  // Reference model: a booted flag, the current fetch address, the address queued behind it,
  // and whether the instruction now fetched is a delay slot.
  logic        m_booted, m_slot, m_dsv, m_mis;
  logic [31:0] m_pc, m_next;

  task automatic model_step(input logic rst_n, input logic le, input logic tb,
                            input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic [31:0] dest;
    m_dsv = 1'b0;
    m_mis = 1'b0;
    if (!rst_n) begin
      m_booted = 1'b0; m_slot = 1'b0; m_pc = 32'h0; m_next = 32'h4;
    end else if (le) begin
      if (!m_booted) begin
        m_booted = 1'b1;
      end else begin
        dest = j ? jt : bt;
        m_pc = m_next;
        if (m_slot) begin
          m_dsv  = tb | j;
          m_slot = 1'b0;
          m_next = m_next + 32'd4;
        end else if (tb | j) begin
          m_slot = 1'b1;
          m_mis  = (dest % 4) != 0;
          m_next = dest - (dest % 4);
        end else begin
          m_next = m_next + 32'd4;
        end
      end
    end
  endtask

  vec_t vecs[18];

  initial begin
    reset_n = 1'b0; load_enable = 1'b0; take_branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;

    //             rst le tb  bt            j  jt            pc            npc          fv ids dsv mis
    vecs[0]  = mkv(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,       32'h4,        0, 0, 0, 0);
    vecs[1]  = mkv(1, 1, 1, 32'h999,      0, 32'h0,       32'h0,       32'h4,        1, 0, 0, 0);
    vecs[2]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h4,       32'h8,        1, 0, 0, 0);
    vecs[3]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h8,       32'hC,        1, 0, 0, 0);
    vecs[4]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'hC,       32'h10,       1, 0, 0, 0);
    vecs[5]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h10,      32'h14,       1, 0, 0, 0);
    vecs[6]  = mkv(1, 1, 1, 32'h40,       0, 32'h0,       32'h14,      32'h40,       1, 1, 0, 0);
    vecs[7]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h40,      32'h44,       1, 0, 0, 0);
    vecs[8]  = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h44,      32'h48,       1, 0, 0, 0);
    vecs[9]  = mkv(1, 1, 1, 32'h200,      1, 32'h100,     32'h48,      32'h100,      1, 1, 0, 0);
    vecs[10] = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h100,     32'h104,      1, 0, 0, 0);
    vecs[11] = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h104,     32'h108,      1, 0, 0, 0);
    vecs[12] = mkv(1, 1, 1, 32'h300,      0, 32'h0,       32'h108,     32'h300,      1, 1, 0, 0);
    vecs[13] = mkv(1, 1, 0, 32'h0,        1, 32'h80,      32'h300,     32'h304,      1, 0, 1, 0);
    vecs[14] = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h304,     32'h308,      1, 0, 0, 0);
    vecs[15] = mkv(1, 1, 1, 32'h43,       0, 32'h0,       32'h308,     32'h40,       1, 1, 0, 1);
    vecs[16] = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h40,      32'h44,       1, 0, 0, 0);
    vecs[17] = mkv(1, 1, 0, 32'h0,        0, 32'h0,       32'h44,      32'h48,       1, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 18; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Stall in the delay slot with a redirect present: nothing moves, no pulse.
    apply("stall_enter", mkv(1, 1, 0, 32'h0, 1, 32'h200, 32'h48, 32'h200, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      apply($sformatf("stall%0d", i), mkv(1, 0, 1, 32'h700, 1, 32'h800,
                                          32'h48, 32'h200, 1, 1, 0, 0));
    apply("stall_resume", mkv(1, 1, 0, 32'h0, 0, 32'h0, 32'h200, 32'h204, 1, 0, 0, 0));
    apply("ds_enter", mkv(1, 1, 1, 32'h500, 0, 32'h0, 32'h204, 32'h500, 1, 1, 0, 0));
    apply("ds_drop", mkv(1, 1, 1, 32'h600, 0, 32'h0, 32'h500, 32'h504, 1, 0, 1, 0));
    apply("pulse_clr", mkv(1, 0, 0, 32'h0, 0, 32'h0, 32'h500, 32'h504, 1, 0, 0, 0));
    apply("rst_in_stall", mkv(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 0, 0, 0, 0));

    // Wrap-around of the sequential PC at the top of the address space.
    apply("wrap_boot", mkv(1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 1, 0, 0, 0));
    apply("wrap_jmp", mkv(1, 1, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'h4, 32'hFFFF_FFF8, 1, 1, 0, 0));
    apply("wrap_f8", mkv(1, 1, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 0, 0, 0));
    apply("wrap_fc", mkv(1, 1, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 0));
    apply("wrap_0", mkv(1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 1, 0, 0, 0));

    // Random traffic against the reference model, starting from a fresh reset.
    model_step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    apply("rnd_rst", mkv(0, 1, 0, 32'h0, 0, 32'h0, m_pc, m_next, m_booted, m_slot, m_dsv, m_mis));
    for (int i = 0; i < 2000; i++) begin
      logic        r_rst, r_le, r_tb, r_j;
      logic [31:0] r_bt, r_jt;
      r_rst = ($urandom_range(99) >= 2);
      r_le  = ($urandom_range(99) < 80);
      r_tb  = ($urandom_range(99) < 25);
      r_j   = ($urandom_range(99) < 15);
      r_bt  = $urandom;
      r_jt  = $urandom;
      if ($urandom_range(3) != 0) r_bt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) r_jt[1:0] = 2'b00;
      model_step(r_rst, r_le, r_tb, r_bt, r_j, r_jt);
      apply($sformatf("rnd%0d", i), mkv(r_rst, r_le, r_tb, r_bt, r_j, r_jt,
                                       m_pc, m_next, m_booted, m_slot, m_dsv, m_mis));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
